sram_port_arb: RTL and testbench

Two-requester arbiter that shares a single synchronous-read SRAM port between the instruction-fetch side and the load/store side of the multi-cycle CPU. It sits between the CPU state machine and a unified memory. Each request is accepted with a same-cycle grant, and the arbiter answers with a one-cycle response pulse. Data side has priority by default, and an anti-starvation counter bounds how long fetch can be held off.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/sram_port_arb_sel.sv | 21 ++
 rtl/sram_port_arb.sv | 98 +++++++++
 tb/tb_sram_port_arb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-side blocks: the owner encoding
// and the width helper for the starve counter.
package cpu_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Counter must be able to hold MAX_WAIT itself.
  function automatic int wcnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sram_port_arb_sel.sv
// Combinational port selection for sram_port_arb. SRAM_ARB_RR_EN selects
// round-robin on contention; otherwise D wins unless fetch is saturated.
module arb_sel (
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_sat,
  input  logic i_rr_i,
  output logic o_sel_i
);

`ifdef SRAM_ARB_RR_EN
  logic w_unused_sat;
  assign w_unused_sat = i_sat;
  assign o_sel_i = i_ireq & (~i_dreq | i_rr_i);
`else
  logic w_unused_rr;
  assign w_unused_rr = i_rr_i;
  assign o_sel_i = i_ireq & (~i_dreq | i_sat);
`endif

endmodule

// File: rtl/sram_port_arb.sv
// Two-port arbiter sharing one synchronous-read SRAM port between fetch (I)
// and load/store (D). Define SRAM_ARB_RR_EN for round-robin on contention.
module sram_port_arb
  import cpu_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_resp,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_resp,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int WCW = wcnt_w(MAX_WAIT);

  owner_e         r_owner;
  owner_e         w_owner_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_rr_ptr_i;
  logic           w_sel_i;
  logic           w_sat;
  logic           w_i_gnt;
  logic           w_d_gnt;
  logic           w_contend;

  assign w_sat     = (r_wait_cnt == WCW'(MAX_WAIT));
  assign w_contend = i_req & d_req;

  arb_sel u_sel (
    .i_ireq  (i_req),
    .i_dreq  (d_req),
    .i_sat   (w_sat),
    .i_rr_i  (r_rr_ptr_i),
    .o_sel_i (w_sel_i)
  );

  // Reset gates every combinational grant so nothing reaches the SRAM.
  assign w_i_gnt = resetn & i_req & w_sel_i;
  assign w_d_gnt = resetn & d_req & ~w_sel_i;
  assign i_gnt   = w_i_gnt;
  assign d_gnt   = w_d_gnt;

  assign ram_en    = w_i_gnt | w_d_gnt;
  assign ram_we    = w_d_gnt & d_we;
  assign ram_wdata = w_d_gnt ? d_wdata : '0;

  always_comb begin
    ram_addr = '0;
    if (w_i_gnt)      ram_addr = i_addr;
    else if (w_d_gnt) ram_addr = d_addr;
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_i_gnt)      w_owner_nxt = OWN_I;
    else if (w_d_gnt) w_owner_nxt = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= '0;
      r_rr_ptr_i <= 1'b1;
    end else begin
      r_owner <= w_owner_nxt;
      if (!i_req || w_i_gnt)
        r_wait_cnt <= '0;
      else if (!w_sat)
        r_wait_cnt <= r_wait_cnt + WCW'(1);
      // Pointer hands preference to the loser of each contended grant.
      if (w_contend && (w_i_gnt || w_d_gnt))
        r_rr_ptr_i <= ~w_i_gnt;
    end
  end

  assign i_resp  = (r_owner == OWN_I);
  assign d_resp  = (r_owner == OWN_D);
  assign i_rdata = i_resp ? ram_rdata : '0;
  assign d_rdata = d_resp ? ram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed table-driven bench for sram_port_arb with a small SRAM model.
module tb_sram_port_arb;
  import cpu_mem_pkg::*;

  localparam logic [31:0] IA = 32'h1c000000;
  localparam logic [31:0] DA = 32'h00000100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_resp, d_gnt, d_resp;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arb #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_resp(d_resp), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Read data registered one cycle after enable; held when idle, cleared on write.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[9:2]] <= ram_wdata;
        ram_rdata <= 32'h0;
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ir;
    logic        dr;
    logic        dwe;
    logic [31:0] dwd;
    logic        eig;
    logic        edg;
    logic        ewe;
    logic        eir;
    logic        edr;
    logic [31:0] eird;
    logic [31:0] edrd;
    int          ecnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic ir, logic dr, logic dwe, logic [31:0] dwd,
                              logic eig, logic edg, logic ewe, logic eir, logic edr,
                              logic [31:0] eird, logic [31:0] edrd, int ecnt, logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dwe = dwe; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.ewe = ewe; v.eir = eir; v.edr = edr;
    v.eird = eird; v.edrd = edrd; v.ecnt = ecnt; v.eaddr = eaddr;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[0] = 32'h02800c0c;
    ram_rdata = 32'h0;
    resetn = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = IA; d_addr = DA; d_wdata = 32'h0;

    //   rst ir dr we wdata         ig dg we ir dr ird           drd           cnt addr
    add(0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0); // gnt forced off in reset
    add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
    add(1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 32'h0,        32'h0,        0, IA);    // I-only read
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 32'h02800c0c, 32'h0,        0, 32'h0);
    add(1, 0, 1, 1, 32'hdeadbeef,   0, 1, 1, 0, 0, 32'h0,        32'h0,        0, DA);    // store
    add(1, 0, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'h0,        0, DA);    // load, store resp
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,        32'hdeadbeef, 0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
`ifdef SRAM_ARB_RR_EN
    add(1, 1, 1, 0, 32'h0,          1, 0, 0, 0, 0, 32'h0,        32'h0,        0, IA);
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 1, 0, 32'h02800c0c, 32'h0,        0, DA);
    add(1, 1, 1, 0, 32'h0,          1, 0, 0, 0, 1, 32'h0,        32'hdeadbeef, 1, IA);
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 1, 0, 32'h02800c0c, 32'h0,        0, DA);
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,        32'hdeadbeef, 1, 32'h0);
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
`else
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,        32'h0,        0, DA);    // contention
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'hdeadbeef, 1, DA);
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'hdeadbeef, 2, DA);
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'hdeadbeef, 3, DA);
    add(1, 1, 1, 0, 32'h0,          1, 0, 0, 0, 1, 32'h0,        32'hdeadbeef, 4, IA);    // saturated
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 32'h02800c0c, 32'h0,        0, 32'h0);
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,        32'h0,        0, DA);    // withdrawn fetch
    add(1, 1, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'hdeadbeef, 1, DA);
    add(1, 0, 1, 0, 32'h0,          0, 1, 0, 0, 1, 32'h0,        32'hdeadbeef, 2, DA);
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,        32'hdeadbeef, 0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
`endif

    repeat (2) @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      resetn = tbl[r].rst; i_req = tbl[r].ir; d_req = tbl[r].dr;
      d_we = tbl[r].dwe; d_wdata = tbl[r].dwd;
      #2;
      chk("i_gnt",    r, {31'h0, i_gnt},  {31'h0, tbl[r].eig});
      chk("d_gnt",    r, {31'h0, d_gnt},  {31'h0, tbl[r].edg});
      chk("ram_en",   r, {31'h0, ram_en}, {31'h0, tbl[r].eig | tbl[r].edg});
      chk("ram_we",   r, {31'h0, ram_we}, {31'h0, tbl[r].ewe});
      chk("ram_addr", r, ram_addr, tbl[r].eaddr);
      chk("i_resp",   r, {31'h0, i_resp}, {31'h0, tbl[r].eir});
      chk("d_resp",   r, {31'h0, d_resp}, {31'h0, tbl[r].edr});
      chk("i_rdata",  r, i_rdata, tbl[r].eird);
      chk("d_rdata",  r, d_rdata, tbl[r].edrd);
      if (tbl[r].rst)
        chk("wait_cnt", r, 32'(dut.r_wait_cnt), 32'(tbl[r].ecnt));
      if (tbl[r].ewe)
        chk("ram_wdata", r, ram_wdata, tbl[r].dwd);
    end

    // Reset asserted in the cycle a load would be granted.
    @(negedge clk);
    resetn = 1'b0; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
    #2;
    chk("rst_d_gnt",  100, {31'h0, d_gnt},  32'h0);
    chk("rst_ram_en", 100, {31'h0, ram_en}, 32'h0);
    chk("rst_addr",   100, ram_addr, 32'h0);
    @(negedge clk);
    resetn = 1'b1; d_req = 1'b0;
    #2;
    chk("rst_d_resp", 101, {31'h0, d_resp}, 32'h0);
    chk("rst_d_rdata", 101, d_rdata, 32'h0);
    chk("rst_owner",  101, 32'(dut.r_owner), 32'(OWN_NONE));

    // Back-to-back loads: response of one overlaps the next grant.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0;
    #2;
    chk("b2b_gnt0", 102, {31'h0, d_gnt}, 32'h1);
    @(negedge clk);
    #2;
    chk("b2b_gnt1", 103, {31'h0, d_gnt}, 32'h1);
    chk("b2b_resp1", 103, d_rdata, 32'hdeadbeef);
    @(negedge clk);
    d_req = 1'b0;
    #2;
    chk("b2b_resp2", 104, {31'h0, d_resp}, 32'h1);
    @(negedge clk);
    #2;
    chk("b2b_idle", 105, {31'h0, d_resp}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
